// File: rtl/legv8_fetch_pkg.sv
// Shared types and constants for the LEGv8 instruction-fetch stage.
package legv8_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_FAULT = 2'd3
  } fetch_state_t;

  localparam int INSTR_W    = 32;
  localparam int ADDR_W     = 64;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 21;
  localparam logic [ADDR_W-1:0] PC_INCR = 64'd4;

endpackage

// File: rtl/legv8_fetch_if.sv
// Instruction-memory req/ack bus between the fetch unit (master) and imem (slave).
interface legv8_fetch_if;
  import legv8_fetch_pkg::*;

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);

endinterface

// File: rtl/legv8_next_pc.sv
// Combinational next-PC selection: unconditional branch, taken CBZ-style branch, or PC+4.
module legv8_next_pc
  import legv8_fetch_pkg::*;
(
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] branch_offset,
  input  logic              branch,
  input  logic              uncond_branch,
  input  logic              zero,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] target;

  // Word offset to byte offset; the two MSBs fall off and the add wraps mod 2^64.
  assign target = pc + (branch_offset << 2);

  always_comb begin
    next_pc = pc + PC_INCR;
    if (uncond_branch) begin
      next_pc = target;
    end else if (branch && zero) begin
      next_pc = target;
    end
  end

endmodule

// File: rtl/legv8_fetch_unit.sv
// Fetch/PC-sequencing FSM: requests one instruction, holds it while the datapath executes, then advances PC.
module legv8_fetch_unit
  import legv8_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC     = 64'h0,
  parameter int                IMEM_TIMEOUT = 16
) (
  input  logic                           CLK,
  input  logic                           Reset_L,
  legv8_fetch_if.master                  imem,
  output logic [INSTR_W-1:0]             Instruction,
  output logic [OPCODE_MSB-OPCODE_LSB:0] Opcode,
  output logic                           instr_valid,
  input  logic                           exec_done,
  input  logic                           Branch,
  input  logic                           Uncondbranch,
  input  logic                           Zero,
  input  logic [ADDR_W-1:0]              BranchOffset,
  output logic [ADDR_W-1:0]              PC,
  output logic                           fetch_fault
);

  localparam int CNT_W = (IMEM_TIMEOUT > 1) ? $clog2(IMEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(IMEM_TIMEOUT - 1);

  fetch_state_t       state;
  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  next_pc;
  logic [INSTR_W-1:0] instr_q;
  logic [CNT_W-1:0]   wait_cnt;
  logic               req_q;
  logic               valid_q;
  logic               fault_q;

  legv8_next_pc u_next_pc (
    .pc            (pc_q),
    .branch_offset (BranchOffset),
    .branch        (Branch),
    .uncond_branch (Uncondbranch),
    .zero          (Zero),
    .next_pc       (next_pc)
  );

  // Outputs are registered alongside the state so they change only on CLK.
  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      state    <= S_IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      wait_cnt <= '0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_FETCH;
          req_q <= 1'b1;
        end
        S_FETCH: begin
          // An ack on the limit cycle still wins over the timeout.
          if (imem.imem_ack) begin
            instr_q  <= imem.imem_rdata;
            wait_cnt <= '0;
            req_q    <= 1'b0;
            valid_q  <= 1'b1;
            state    <= S_EXEC;
          end else if (wait_cnt == CNT_LIMIT) begin
            req_q   <= 1'b0;
            fault_q <= 1'b1;
            state   <= S_FAULT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_EXEC: begin
          if (exec_done) begin
            pc_q    <= next_pc;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            state   <= S_FETCH;
          end
        end
        S_FAULT: begin
          state <= S_FAULT;
        end
        default: begin
          state   <= S_IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign Instruction    = instr_q;
  assign Opcode         = instr_q[OPCODE_MSB:OPCODE_LSB];
  assign instr_valid    = valid_q;
  assign PC             = pc_q;
  assign fetch_fault    = fault_q;

endmodule

// File: tb/tb_legv8_fetch_unit.sv
// Scoreboard bench for legv8_fetch_unit: expected fetch addresses and opcodes are queued when stimulus is driven.
module tb_legv8_fetch_unit;
  import legv8_fetch_pkg::*;

  logic        CLK = 1'b0;
  logic        Reset_L;
  logic [31:0] Instruction;
  logic [10:0] Opcode;
  logic        instr_valid;
  logic        exec_done;
  logic        Branch;
  logic        Uncondbranch;
  logic        Zero;
  logic [63:0] BranchOffset;
  logic [63:0] PC;
  logic        fetch_fault;

  int total = 0;
  int bad   = 0;

  logic [63:0] addr_q[$];
  logic [10:0] op_q[$];
  logic [63:0] exp_pc;

  legv8_fetch_if bus ();

  legv8_fetch_unit #(.RESET_PC(64'h0), .IMEM_TIMEOUT(4)) dut (
    .CLK          (CLK),
    .Reset_L      (Reset_L),
    .imem         (bus.master),
    .Instruction  (Instruction),
    .Opcode       (Opcode),
    .instr_valid  (instr_valid),
    .exec_done    (exec_done),
    .Branch       (Branch),
    .Uncondbranch (Uncondbranch),
    .Zero         (Zero),
    .BranchOffset (BranchOffset),
    .PC           (PC),
    .fetch_fault  (fetch_fault)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    Reset_L = 1'b0;
    bus.imem_ack = 1'b0;
    exec_done = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_req", bus.imem_req, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_opcode", Opcode, 0);
    check("rst_instr", Instruction, 0);
    check("rst_pc", PC, 0);
    check("rst_fault", fetch_fault, 0);
    Reset_L = 1'b1;
    exp_pc = 64'h0;
    addr_q.delete();
    op_q.delete();
    addr_q.push_back(64'h0);
  endtask

  // Waits (bounded) for imem_req and checks the address against the scoreboard.
  task automatic wait_req(output bit ok);
    int n = 0;
    ok = 1'b0;
    while (bus.imem_req !== 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (bus.imem_req !== 1'b1) begin
      check("req_timeout", 0, 1);
      return;
    end
    ok = 1'b1;
    if (addr_q.size() == 0) check("addr_q_empty", 1, 0);
    else check("fetch_addr", bus.imem_addr, addr_q.pop_front());
  endtask

  task automatic do_fetch(input int delay, input logic [31:0] data, input bit hold_done);
    bit ok;
    wait_req(ok);
    if (!ok) return;
    exec_done = hold_done;
    repeat (delay) @(negedge CLK);
    exec_done = 1'b0;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = data;
    op_q.push_back(data[31:21]);
    @(negedge CLK);
    bus.imem_ack = 1'b0;
  endtask

  task automatic do_exec(input int hold, input logic br, input logic ub, input logic z,
                         input logic [63:0] off);
    logic [10:0] op_now;
    check("valid_lat", instr_valid, 1);
    check("req_low_exec", bus.imem_req, 0);
    check("exec_pc", PC, exp_pc);
    if (op_q.size() == 0) check("op_q_empty", 1, 0);
    else check("opcode", Opcode, op_q.pop_front());
    op_now = Opcode;
    for (int i = 0; i < hold; i++) begin
      bus.imem_ack = (i == 2);
      bus.imem_rdata = 32'h0000_0000;
      @(negedge CLK);
      check("hold_opcode", Opcode, op_now);
      check("hold_pc", PC, exp_pc);
      check("hold_noreq", bus.imem_req, 0);
    end
    bus.imem_ack = 1'b0;
    Branch = br;
    Uncondbranch = ub;
    Zero = z;
    BranchOffset = off;
    exec_done = 1'b1;
    if (ub === 1'b1 || (br === 1'b1 && z === 1'b1)) exp_pc = exp_pc + {off[61:0], 2'b00};
    else exp_pc = exp_pc + 64'd4;
    addr_q.push_back(exp_pc);
    @(negedge CLK);
    exec_done = 1'b0;
    Branch = 1'b0;
    Uncondbranch = 1'b0;
    Zero = 1'b0;
    check("req_lat", bus.imem_req, 1);
    check("valid_drop", instr_valid, 0);
  endtask

  initial begin
    bit ok;
    int n;
    Reset_L = 1'b0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    exec_done = 1'b0;
    Branch = 1'b0;
    Uncondbranch = 1'b0;
    Zero = 1'b0;
    BranchOffset = '0;
    do_reset();

    do_fetch(1, 32'hF840_0000, 1'b0);
    check("ldur_opcode", Opcode, 11'h7C2);
    do_exec(0, 1'b0, 1'b0, 1'b0, 64'd0);
    do_fetch(0, 32'h1400_000F, 1'b0);
    do_exec(1, 1'b0, 1'b1, 1'b0, 64'd15);
    do_fetch(3, 32'hB400_0060, 1'b1);
    do_exec(10, 1'b1, 1'b0, 1'b1, 64'd3);
    do_fetch(2, 32'h17FF_FFFD, 1'b0);
    do_exec(0, 1'b0, 1'b1, 1'b0, -64'sd3);
    do_fetch(0, 32'hB400_0060, 1'b0);
    do_exec(0, 1'b1, 1'b0, 1'b0, 64'd3);
    do_fetch(1, 32'h17FF_FFF3, 1'b0);
    do_exec(0, 1'b0, 1'b1, 1'b0, -64'sd13);
    do_fetch(0, 32'h17FF_FFFC, 1'b0);
    check("pc_0x10", PC, 64'h10);
    do_exec(0, 1'bx, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC);
    do_fetch(0, 32'h17FF_FFFF, 1'b0);
    do_exec(0, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    do_fetch(0, 32'h8B02_0020, 1'b0);
    check("pc_wrapped", PC, 64'hFFFF_FFFF_FFFF_FFFC);
    do_exec(0, 1'b0, 1'b0, 1'b1, 64'd0);
    do_fetch(0, 32'hB400_0020, 1'b0);
    do_exec(0, 1'b1, 1'b0, 1'b1, 64'h4000_0000_0000_0001);

    // Withheld ack: expect exactly four request cycles, then a sticky fault.
    wait_req(ok);
    n = 1;
    while (ok && bus.imem_req === 1'b1 && n < 20) begin
      @(negedge CLK);
      if (bus.imem_req === 1'b1) n++;
    end
    check("fault_req_cycles", n, 4);
    check("fault_set", fetch_fault, 1);
    check("fault_req_low", bus.imem_req, 0);
    bus.imem_ack = 1'b1;
    repeat (5) @(negedge CLK);
    bus.imem_ack = 1'b0;
    check("fault_sticky", fetch_fault, 1);
    check("fault_no_valid", instr_valid, 0);
    do_reset();

    do_fetch(0, 32'h1400_0020, 1'b0);
    do_exec(0, 1'b0, 1'b1, 1'b0, 64'd32);

    // Reset while the 0x80 fetch is outstanding, with an ack on the same edge.
    wait_req(ok);
    check("midrst_pc", PC, 64'h80);
    Reset_L = 1'b0;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'hFFFF_FFFF;
    @(negedge CLK);
    check("midrst_req", bus.imem_req, 0);
    check("midrst_pc0", PC, 64'h0);
    check("midrst_instr", Instruction, 0);
    check("midrst_valid", instr_valid, 0);
    bus.imem_ack = 1'b0;
    Reset_L = 1'b1;
    exp_pc = 64'h0;
    addr_q.delete();
    addr_q.push_back(64'h0);

    do_fetch(0, 32'hD280_0000, 1'b0);
    do_exec(2, 1'b0, 1'b0, 1'b0, 64'd0);
    wait_req(ok);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/legv8_fetch_unit.md
Name: legv8_fetch_unit

Overview:
Instruction-fetch and PC-sequencing stage for the LEGv8 single-cycle core. It sits directly upstream of the control decoder.
- Fetches one 32-bit instruction per cycle of execution from instruction memory over a req/ack handshake.
- Presents Opcode (bits 31:21) to the control decoder and holds it stable while the datapath executes.
- Consumes the decoder's Branch/Uncondbranch outputs plus the ALU Zero flag to compute the next PC.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset.
IMEM_TIMEOUT, 16, maximum cycles to wait for imem_ack before declaring a fault (>=1).

Ports:
CLK  in  1  rising-edge clock
Reset_L  in  1  synchronous active-low reset
imem_req  out  1  fetch request, held high until acked
imem_addr  out  64  fetch address, equals PC while imem_req=1
imem_ack  in  1  memory response valid; imem_rdata sampled on same edge
imem_rdata  in  32  instruction word
Instruction  out  32  latched instruction
Opcode  out  11  Instruction[31:21], to control decoder
instr_valid  out  1  Instruction/Opcode valid, datapath may execute
exec_done  in  1  datapath finished current instruction; branch inputs valid this cycle
Branch  in  1  from control decoder
Uncondbranch  in  1  from control decoder
Zero  in  1  ALU zero flag
BranchOffset  in  64  sign-extended word offset (unshifted) from the immediate extender
PC  out  64  current PC
fetch_fault  out  1  sticky imem timeout flag

Behaviour:
- All state updates on rising CLK. Reset_L=0 at an edge forces:
  - state=S_IDLE, PC=RESET_PC, Instruction=32'h0, timeout counter=0, fetch_fault=0.
  - Outputs during/after reset: imem_req=0, instr_valid=0, Opcode=11'h0.
- States and transitions:
  - S_IDLE: outputs inactive; next edge with Reset_L=1 -> S_FETCH.
  - S_FETCH:
    - imem_req=1, imem_addr=PC, counter increments each cycle.
    - imem_ack=1 -> latch imem_rdata into Instruction, clear counter, -> S_EXEC.
    - If the counter reaches IMEM_TIMEOUT-1 with no ack -> S_FAULT.
  - S_EXEC:
    - instr_valid=1; Instruction/Opcode stable.
    - Waits any number of cycles for exec_done=1; on that edge PC<=next_pc, -> S_FETCH.
  - S_FAULT: fetch_fault=1, imem_req=0, instr_valid=0; remains until reset.
- next_pc (combinational, sampled only when exec_done=1 in S_EXEC), evaluated in priority order:
  - Uncondbranch=1 -> PC + (BranchOffset<<2). Branch is ignored, including X.
  - else Branch=1 and Zero=1 -> PC + (BranchOffset<<2).
  - else PC + 4.
- Arithmetic is 64-bit modulo 2^64; wrap-around is permitted, with no overflow detection. BranchOffset<<2 discards its top two bits.
- Latency:
  - ack in cycle N -> instr_valid=1 from cycle N+1.
  - exec_done in cycle M -> imem_req=1 with the new PC from cycle M+1.
  - Minimum 2 cycles per instruction.
- Boundary conditions:
  - imem_ack outside S_FETCH is ignored.
  - exec_done outside S_EXEC is ignored.
  - imem_ack on the same edge the counter hits its limit: ack wins, no fault.
  - Reset asserted mid-fetch or mid-exec: return to S_IDLE next edge; any in-flight ack is discarded. The memory must tolerate a dropped request.
  - IMEM_TIMEOUT=1: fault unless ack arrives in the first S_FETCH cycle.
- PC bits [1:0] remain 0 provided RESET_PC is word-aligned.

Decomposition:
- Package legv8_fetch_pkg:
  - state enum {S_IDLE, S_FETCH, S_EXEC, S_FAULT};
  - INSTR_W=32, ADDR_W=64;
  - OPCODE_MSB=31, OPCODE_LSB=21;
  - PC_INCR=64'd4.
- One sub-module, legv8_next_pc: purely combinational adder/mux implementing the next_pc rule. It is reused by the later pipelined core.

Test Plan:
- Reset with RESET_PC=0, memory acks 1 cycle after req with 32'hF8400000 at addr 0 -> first imem_req cycle after S_IDLE, addr=0; Opcode=11'h7C2 one cycle after ack; exec_done -> next imem_addr=4.
- CBZ taken: PC=0x40, Branch=1, Zero=1, BranchOffset=3, exec_done -> next imem_addr=0x4C. Same with Zero=0 -> 0x44.
- B backward with Branch=X: PC=0x10, Uncondbranch=1, BranchOffset=64'hFFFF_FFFF_FFFF_FFFC -> next PC=0x0. PC=0, offset=-1 -> PC=64'hFFFF_FFFF_FFFF_FFFC (wrap).
- Ack latency: IMEM_TIMEOUT=4, ack delayed 3 cycles -> fetch succeeds. Ack withheld -> fetch_fault=1 after 4 req cycles, imem_req drops, fault stays set until Reset_L=0.
- Reset mid-fetch: Reset_L=0 while imem_req=1 with PC=0x80 -> next edge imem_req=0, PC=RESET_PC. An ack arriving during reset is ignored, and Instruction stays 0.
- exec_done held low for 10 cycles in S_EXEC -> Opcode and PC stable throughout; no imem_req issued.
